uart_rx_os: RTL and testbench

16x-oversampled UART byte receiver: 8N1 frames on a single serial input become parallel bytes with a one-cycle valid strobe. Sits directly upstream of display_control and drives its rx_data/valid inputs. Rejects glitches via a 2-FF synchroniser, false-start check and 3-sample majority vote, and reports framing errors.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_os.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the oversampled UART blocks: receiver state
// encoding, the oversampling ratio, the mid-bit sample position, default
// clock/baud values and a helper that derives the baud-tick divider.
// No ports (package).

package uart_pkg;

    // Receiver states. PARITY is only reachable in 8E1 builds.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int OVERSAMPLE       = 16;
    localparam int SAMPLE_MID       = 8;
    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    // Clocks per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running divider producing a one-cycle tick every DIV clocks. A
// synchronous clear restarts the phase so a receiver can align its
// sampling grid to a start edge.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   synchronous counter clear (restarts the tick phase)
//   tick_o  high for one cycle when the counter reaches DIV-1

module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o = (count_q == CW'(DIV - 1));

    // Counter wraps after the tick; a clear wins over the normal count.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clr_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os
// 16x-oversampled UART receiver. 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined) on din become bytes on data with a one-cycle valid strobe.
// Glitches are rejected by a 2-FF synchroniser, a false-start check and a
// 3-sample majority vote taken around mid-bit.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   din        raw asynchronous serial line, idle high
//   data       last good byte received (LSB first on the line)
//   valid      one-cycle pulse, data updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   perr       one-cycle pulse, parity mismatch (always 0 without parity)
//   busy       high while a frame is in progress
// Build option: define UART_RX_PARITY_EN for 8E1 framing with parity check.

module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       perr,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    localparam logic [3:0] S_FIRST = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] S_MID   = 4'(SAMPLE_MID);
    localparam logic [3:0] S_LAST  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] S_END   = 4'(OVERSAMPLE - 1);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [3:0]  s_cnt_q, s_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        armed_q, armed_d;
    logic        din_s;
    logic        tick;
    logic        baud_clr;
    logic        maj;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    assign din_s     = sync2_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign perr      = perr_q;
`else
    assign perr      = 1'b0;
`endif

    // Majority of the two stored samples and the live third sample.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & din_s) | (samp_q[1] & din_s);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    // Next-state logic. armed tracks whether the line has been seen high
    // since the last stop resolution, so a held-low line (break) cannot
    // retrigger a frame until it returns high and falls again.
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        samp_d    = samp_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        armed_d   = armed_q | din_s;
        baud_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif

        if (state_q != IDLE && tick) begin
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == S_FIRST) samp_d[0] = din_s;
            if (s_cnt_q == S_MID)   samp_d[1] = din_s;
        end

        case (state_q)
            IDLE: begin
                if (!din_s && armed_q) begin
                    state_d  = START;
                    s_cnt_d  = 4'd0;
                    baud_clr = 1'b1;
                end
            end
            START: begin
                if (tick && s_cnt_q == S_LAST && maj) begin
                    state_d = IDLE;
                end else if (tick && s_cnt_q == S_END) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (tick && s_cnt_q == S_LAST) begin
                    shreg_d = {maj, shreg_q[7:1]};
                end
                if (tick && s_cnt_q == S_END) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && s_cnt_q == S_LAST) begin
                    par_d = maj;
                end
                if (tick && s_cnt_q == S_END) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && s_cnt_q == S_LAST) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                    if (!maj) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shreg_q) ^ par_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, including the input synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            s_cnt_q   <= 4'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            samp_q    <= 2'b00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= din;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            samp_q    <= samp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os
// Directed bench for uart_rx_os. Runs the receiver with a small divider
// (DIV=4, 64 clocks per bit) so whole frames stay short.

module tb_uart_rx_os;

    localparam int CLK_FREQ      = 640_000;
    localparam int BAUD          = 10_000;
    localparam int DIV           = 4;
    localparam int BIT_CLKS      = 64;
    localparam int FAST_BIT_CLKS = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       perr;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int validCount = 0;
    int ferrCount  = 0;
    int perrCount  = 0;
    int bothHigh   = 0;
    logic [7:0] rxq[$];

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .perr     (perr),
        .busy     (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Output monitor: counts strobes and records every byte delivered
    always @(negedge clk) begin
        if (valid) begin
            validCount++;
            rxq.push_back(data);
        end
        if (frame_err) ferrCount++;
        if (perr) perrCount++;
        if (valid && frame_err) bothHigh++;
    end

    function automatic logic evenPar(input logic [7:0] b);
        return ^b;
    endfunction

    // Drives one frame, LSB first, bitClks clocks per bit
    task automatic sendFrame(input logic [7:0] b, input int bitClks,
                             input logic stopBit, input logic parBit);
        @(negedge clk);
        din = 1'b0;
        repeat (bitClks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (bitClks) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        din = parBit;
        repeat (bitClks) @(negedge clk);
`else
        if (parBit === 1'bx) din = 1'b1;
`endif
        din = stopBit;
        repeat (bitClks) @(negedge clk);
        din = 1'b1;
    endtask

    task automatic idleLine(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (perr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%b exp=0", perr); end
        idleLine(10);
    endtask

    task automatic test_basic();
        int v0, f0;
        v0 = validCount; f0 = ferrCount;
        sendFrame(8'hA5, BIT_CLKS, 1'b1, evenPar(8'hA5));
        idleLine(40);
        total++; if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL basic_valid_count got=%0d exp=1", validCount - v0); end
        total++; if (data !== 8'hA5) begin bad++; $display("[TB] FAIL basic_data got=%h exp=a5", data); end
        total++; if (ferrCount - f0 != 0) begin bad++; $display("[TB] FAIL basic_ferr got=%0d exp=0", ferrCount - f0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0, q0;
        logic [7:0] expB [3];
        expB[0] = 8'h31; expB[1] = 8'h32; expB[2] = 8'h33;
        v0 = validCount; q0 = rxq.size();
        for (int i = 0; i < 3; i++) begin
            sendFrame(expB[i], FAST_BIT_CLKS, 1'b1, evenPar(expB[i]));
        end
        idleLine(100);
        total++; if (validCount - v0 != 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", validCount - v0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rxq.size() <= q0 + i) begin
                bad++; $display("[TB] FAIL b2b_byte%0d got=none exp=%h", i, expB[i]);
            end else if (rxq[q0 + i] !== expB[i]) begin
                bad++; $display("[TB] FAIL b2b_byte%0d got=%h exp=%h", i, rxq[q0 + i], expB[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int v0, n;
        v0 = validCount;
        @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        din = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_rise got=%b exp=1", busy); end
        // A false start is resolved on the tenth tick after entering START
        n = 0;
        while (busy && n < 10 * DIV + 2) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_fall got=%b exp=0 after %0d cycles", busy, n); end
        idleLine(20);
        total++; if (validCount - v0 != 0) begin bad++; $display("[TB] FAIL glitch_valid got=%0d exp=0", validCount - v0); end
    endtask

    task automatic test_frame_err();
        int v0, f0, p0;
        v0 = validCount; f0 = ferrCount; p0 = perrCount;
        sendFrame(8'h5A, BIT_CLKS, 1'b0, evenPar(8'h5A));
        idleLine(100);
        total++; if (ferrCount - f0 != 1) begin bad++; $display("[TB] FAIL ferr_count got=%0d exp=1", ferrCount - f0); end
        total++; if (validCount - v0 != 0) begin bad++; $display("[TB] FAIL ferr_valid got=%0d exp=0", validCount - v0); end
        total++; if (data !== 8'h33) begin bad++; $display("[TB] FAIL ferr_data_kept got=%h exp=33", data); end
        total++; if (perrCount - p0 != 0) begin bad++; $display("[TB] FAIL ferr_perr got=%0d exp=0", perrCount - p0); end
    endtask

    task automatic test_break();
        int v0, f0;
        v0 = validCount; f0 = ferrCount;
        sendFrame(8'h00, BIT_CLKS, 1'b0, evenPar(8'h00));
        din = 1'b0;
        repeat (BIT_CLKS * 30) @(negedge clk);
        total++; if (ferrCount - f0 != 1) begin bad++; $display("[TB] FAIL break_ferr got=%0d exp=1", ferrCount - f0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL break_busy got=%b exp=0", busy); end
        idleLine(100);
        sendFrame(8'h55, BIT_CLKS, 1'b1, evenPar(8'h55));
        idleLine(40);
        total++; if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL break_valid got=%0d exp=1", validCount - v0); end
        total++; if (data !== 8'h55) begin bad++; $display("[TB] FAIL break_data got=%h exp=55", data); end
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        v0 = validCount; f0 = ferrCount;
        fork
            sendFrame(8'hFF, BIT_CLKS, 1'b1, evenPar(8'hFF));
            begin
                repeat (BIT_CLKS * 5 + 32) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        idleLine(40);
        total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data_cleared got=%h exp=00", data); end
        sendFrame(8'h0F, BIT_CLKS, 1'b1, evenPar(8'h0F));
        idleLine(40);
        total++; if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL rstmid_valid got=%0d exp=1", validCount - v0); end
        total++; if (data !== 8'h0F) begin bad++; $display("[TB] FAIL rstmid_data got=%h exp=0f", data); end
        total++; if (ferrCount - f0 != 0) begin bad++; $display("[TB] FAIL rstmid_ferr got=%0d exp=0", ferrCount - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        v0 = validCount; p0 = perrCount;
        sendFrame(8'h07, BIT_CLKS, 1'b1, 1'b1);
        idleLine(40);
        total++; if (validCount - v0 != 1) begin bad++; $display("[TB] FAIL par_good_valid got=%0d exp=1", validCount - v0); end
        total++; if (data !== 8'h07) begin bad++; $display("[TB] FAIL par_good_data got=%h exp=07", data); end
        v0 = validCount;
        sendFrame(8'h07, BIT_CLKS, 1'b1, 1'b0);
        idleLine(40);
        total++; if (perrCount - p0 != 1) begin bad++; $display("[TB] FAIL par_bad_perr got=%0d exp=1", perrCount - p0); end
        total++; if (validCount - v0 != 0) begin bad++; $display("[TB] FAIL par_bad_valid got=%0d exp=0", validCount - v0); end
    endtask
`endif

    // Test sequence
    initial begin
        din = 1'b1;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        total++; if (bothHigh != 0) begin bad++; $display("[TB] FAIL valid_ferr_overlap got=%0d exp=0", bothHigh); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
